// File: rtl/sync_filter_n.sv
// Multi-channel synchroniser + debouncer: STAGES-deep sync chain, then a per-channel
// stability counter with registered rise/fall pulses. Optional sticky event bits under SYNC_FILTER_STICKY_EN.
module sync_filter_n #(
    parameter int unsigned          WIDTH    = 8,
    parameter int unsigned          STAGES   = 2,
    parameter int unsigned          DEBOUNCE = 4,
    parameter logic [WIDTH-1:0]     INIT     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef SYNC_FILTER_STICKY_EN
    ,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] evt_sticky
`endif
);

    // A chain shorter than two flops gives no metastability protection.
    localparam int unsigned SYNC_N = (STAGES < 2) ? 2 : STAGES;
    localparam int unsigned CW     = (DEBOUNCE <= 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_q [SYNC_N];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q;
    logic [WIDTH-1:0] s;

    assign s = sync_q[SYNC_N-1];

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    out_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_N; k++) begin
                sync_q[k] <= INIT;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q     <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q[0] <= in_async;
            for (int k = 1; k < SYNC_N; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

`ifdef SYNC_FILTER_STICKY_EN
    logic [WIDTH-1:0] sticky_q, sticky_d;

    // Set from the already-registered pulses, so a set always beats a clear.
    assign sticky_d = (sticky_q & ~evt_clr) | rise_q | fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign evt_sticky = sticky_q;
`endif

endmodule

// File: doc/sync_filter_n.md
Name: sync_filter_n

Overview:
- Multi-channel synchroniser and debouncer for asynchronous inputs entering the system clock domain. Intended inputs are joystick lines, cartridge detect and button strobes.
- Each channel passes through a parametrised-depth flop chain, then a per-channel stability counter. A level changes only after it has been stable for a set number of cycles.
- Registered single-cycle rise and fall pulses are generated per channel.
- The block replaces ad-hoc 2-flop synchronisers wherever a bus of slow async signals enters the core.

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- STAGES, 2, synchroniser flops per channel. Minimum 2; values below 2 are treated as 2.
- DEBOUNCE, 4, consecutive cycles a synchronised value must differ from out before out updates (1..65535). A value of 1 means no filtering beyond one register.
- INIT, {WIDTH{1'b0}}, reset value of every sync flop and of out, per bit.

Ports:
- clk, in, 1: destination clock. The only clock in the block.
- reset, in, 1: synchronous reset, active-high.
- in_async, in, WIDTH: asynchronous inputs. No timing relation to clk.
- out, out, WIDTH: synchronised, debounced levels.
- rise, out, WIDTH: one-cycle pulse per channel when out[i] goes 0->1.
- fall, out, WIDTH: one-cycle pulse per channel when out[i] goes 1->0.
- changed, out, 1: registered OR of all rise and fall bits, asserted in the same cycle as those pulses.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. All flops update on posedge clk only.
- Reset, evaluated at a clk edge with reset=1:
  - sync chain[i] <= INIT[i]; out <= INIT; cnt[i] <= 0; rise/fall/changed <= 0.
  - reset has priority over every other action, including a counter expiring in the same cycle.
- Sync chain:
  - s[i] is the last flop of an STAGES-deep shift register clocked by clk, fed from in_async[i].
  - Only s[i] is used downstream. No logic sits between in_async and the first flop.
- Per-channel filter, each cycle with reset=0:
  - If s[i]==out[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i]==DEBOUNCE-1: out[i] <= s[i]; cnt[i] <= 0. Also rise[i] <= s[i] and fall[i] <= ~s[i] in this same cycle.
  - Else: cnt[i] <= cnt[i]+1; no pulse.
- Counter width:
  - cnt width is clog2(DEBOUNCE), with a minimum of 1.
  - The counter never wraps, because it clears on match or expiry.
- Pulses:
  - rise and fall are registered and go high on the same clk edge that out changes.
  - Each pulse lasts exactly one cycle. rise[i] and fall[i] are never both high.
- Latency:
  - A clean input change, sampled at edge E0, appears on s at E0+STAGES-1.
  - It appears on out and on the pulse at E0+STAGES-1+DEBOUNCE.
  - With STAGES=2 and DEBOUNCE=1, out follows 2 edges after sampling.
- Glitch rejection:
  - Any excursion of s[i] shorter than DEBOUNCE cycles leaves out[i] unchanged and produces no pulse. The counter clears when s returns to out.
- Simultaneous events: channels are fully independent. Any combination of rise and fall bits may assert in one cycle.
- After reset release, if in_async differs from INIT, the normal debounce applies and a pulse is produced. This is intentional: it reports the true level.

Optional Feature:
- Macro: SYNC_FILTER_STICKY_EN.
- When defined, two ports are added:
  - evt_clr, in, WIDTH.
  - evt_sticky, out, WIDTH.
- evt_sticky[i] sets on rise[i] or fall[i] in the cycle after the pulse, and holds until evt_clr[i]=1 at a clk edge.
- A set and a clear in the same cycle leaves the bit set (set wins).
- evt_sticky resets to 0.
- When undefined, both ports and their logic are absent. All other behaviour is identical.

Test Plan:
Each test uses WIDTH=4, STAGES=2, DEBOUNCE=3 and INIT=4'b1000 unless stated otherwise.
1. Reset: reset=1 for 5 cycles while in_async toggles 4'hF/4'h0 -> out=4'b1000 and rise=fall=0 every cycle; changed=0.
2. Clean edge: release reset with in_async=4'b1000, then at edge E0 set in_async[0]=1 and hold -> out[0]=1 and rise=4'b0001 at E0+4 only; changed=1 for one cycle; fall=0.
3. Glitch: in_async[1] high for exactly 2 cycles -> out stays 4'b1000; no rise/fall/changed ever asserted.
4. Simultaneous: at one edge set in_async 4'b1000->4'b0100 -> four cycles later out=4'b0100, rise=4'b0100, fall=4'b1000 in the same cycle.
5. Reset mid-count: raise in_async[0], then assert reset one cycle before expiry -> out=4'b1000, no pulse. After release with the input still high, out[0] rises STAGES-1+DEBOUNCE cycles later.
6. Sticky (macro defined): rise on channel 0 -> evt_sticky=4'b0001 persists. Pulse evt_clr=4'b0001 in the same cycle as a new fall[0] -> bit stays 1. A later clear alone -> 0.
